fetch_ctrl: RTL and testbench

Instruction-fetch controller for the SSOOO out-of-order core. It sequences the program counter into the combinational instruction memory and buffers fetched words with their PCs in a small circular queue. It delivers them in order to dispatch over a valid/ready handshake, and flushes and re-steers on branch/jump redirects. It sits between the instruction memory and the decode/dispatch stage.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_if.sv | 21 ++
 rtl/fetch_fifo.sv | 42 ++++
 rtl/fetch_ctrl.sv | 45 ++++
 tb/tb_fetch_ctrl.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction-fetch controller
package fetch_pkg;
  localparam int IMEM_WORDS_DEFAULT = 64;
  typedef enum logic {FETCH, END} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory, redirect and dispatch signals of the fetch controller
interface fetch_if #(parameter int DEPTH = 4);
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [$clog2(DEPTH):0] q_count;
  logic fetch_done;
  modport master (
    output imem_pc, out_valid, out_inst, out_pc, q_count, fetch_done,
    input imem_inst, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input imem_pc, out_valid, out_inst, out_pc, q_count, fetch_done,
    output imem_inst, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of fetched {pc, inst} entries; clear wins over push
module fetch_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push && !clear) mem_d[tail_q] = din;
    head_d = clear ? '0 : pop ? head_q + AW'(1) : head_q;
    tail_d = clear ? '0 : push ? tail_q + AW'(1) : tail_q;
    count_d = clear ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  assign head = mem_q[head_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencing, fetch FSM and redirect handling in front of fetch_fifo
module fetch_ctrl import fetch_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int IMEM_WORDS = IMEM_WORDS_DEFAULT,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rst,
  fetch_if.master bus
);
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, pc_inc;
  logic push, pop;
  logic [CW-1:0] count;
  fetch_entry_t head, din;
  always_comb begin
    pop = (count != '0) && bus.out_ready;
    push = (state_q == FETCH) && !bus.redirect_valid && ((count < CW'(DEPTH)) || pop);
    pc_inc = pc_q + 32'd1;
    pc_d = bus.redirect_valid ? bus.redirect_pc : push ? pc_inc : pc_q;
    state_d = bus.redirect_valid ? ((bus.redirect_pc < 32'(IMEM_WORDS)) ? FETCH : END)
            : (push && pc_inc >= 32'(IMEM_WORDS)) ? END : state_q;
    din = '{pc: pc_q, inst: bus.imem_inst};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
    end
  end
  // a same-cycle pop is irrelevant under redirect: clear empties everything anyway
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clear(bus.redirect_valid),
    .din(din), .head(head), .count(count)
  );
  assign bus.imem_pc = pc_q;
  assign bus.out_valid = count != '0;
  assign bus.out_inst = head.inst;
  assign bus.out_pc = head.pc;
  assign bus.q_count = count;
  assign bus.fetch_done = (state_q == END) && (count == '0);
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and random checks of fetch_ctrl against a queue-based model
module tb_fetch_ctrl;
  import fetch_pkg::*;
  logic clk = 0;
  logic rst = 1;
  logic armed = 0;
  int checks = 0;
  int errors = 0;
  fetch_if #(.DEPTH(4)) bus ();
  fetch_ctrl #(.DEPTH(4), .IMEM_WORDS(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] pc);
    return {~pc[15:0], pc[15:0]} ^ 32'h5A5A_0000;
  endfunction
  always_comb bus.imem_inst = word(bus.imem_pc);

  fetch_entry_t q[$];
  logic [31:0] mpc = 0;
  bit mend = 0;
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      mpc = 0;
      mend = 0;
    end else if (bus.redirect_valid) begin
      q.delete();
      mpc = bus.redirect_pc;
      mend = bus.redirect_pc >= 64;
    end else begin
      if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
      if (!mend && q.size() < 4) begin
        q.push_back('{pc: mpc, inst: word(mpc)});
        mpc = mpc + 1;
        if (mpc >= 64) mend = 1;
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) if (armed) begin
    chk("m_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("m_count", 32'(bus.q_count), q.size());
    chk("m_done", 32'(bus.fetch_done), 32'(mend && q.size() == 0));
    chk("m_imem_pc", bus.imem_pc, mpc);
    chk("m_count_le4", 32'(bus.q_count <= 3'd4), 32'd1);
    if (q.size() != 0) begin
      chk("m_out_pc", bus.out_pc, q[0].pc);
      chk("m_out_inst", bus.out_inst, q[0].inst);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_zero_checks(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_inst"}, bus.out_inst, 0);
    chk({tag, "_pc"}, bus.out_pc, 0);
    chk({tag, "_count"}, 32'(bus.q_count), 0);
    chk({tag, "_done"}, 32'(bus.fetch_done), 0);
    chk({tag, "_imem_pc"}, bus.imem_pc, 0);
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1;
    bus.redirect_pc = pc;
    step();
    bus.redirect_valid = 0;
  endtask

  initial begin
    bus.out_ready = 1;
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
    step();
    armed = 1;
    step();
    reset_zero_checks("rst1");
    rst = 0;
    for (int n = 1; n <= 65; n++) begin
      step();
      if (n <= 64) chk("seq_pc", bus.out_pc, n - 1);
      if (n == 64) chk("seq_done_lo", 32'(bus.fetch_done), 0);
      if (n == 65) chk("seq_done_hi", 32'(bus.fetch_done), 1);
    end
    rst = 1;
    bus.out_ready = 0;
    step();
    rst = 0;
    for (int n = 0; n < 10; n++) step();
    chk("stall_count", 32'(bus.q_count), 4);
    chk("stall_imem_pc", bus.imem_pc, 4);
    chk("stall_head", bus.out_pc, 0);
    bus.out_ready = 1;
    for (int n = 0; n < 4; n++) step();
    chk("drain_pc4", bus.out_pc, 4);
    step();
    chk("pre_redir_pc", bus.out_pc, 5);
    chk("pre_redir_cnt", 32'(bus.q_count), 4);
    redirect(37);
    chk("redir_valid", 32'(bus.out_valid), 0);
    chk("redir_imem_pc", bus.imem_pc, 37);
    step();
    chk("redir_pc37", bus.out_pc, 37);
    chk("redir_inst37", bus.out_inst, word(37));
    redirect(64);
    chk("end_done", 32'(bus.fetch_done), 1);
    redirect(64);
    chk("end_done_kept", 32'(bus.fetch_done), 1);
    redirect(10);
    chk("refetch_done", 32'(bus.fetch_done), 0);
    chk("refetch_imem_pc", bus.imem_pc, 10);
    step();
    chk("refetch_pc10", bus.out_pc, 10);
    bus.out_ready = 0;
    for (int n = 0; n < 5; n++) step();
    chk("full_before_rst", 32'(bus.q_count), 4);
    rst = 1;
    bus.redirect_valid = 1;
    bus.redirect_pc = 20;
    step();
    reset_zero_checks("rst2");
    rst = 0;
    bus.redirect_valid = 0;
    bus.out_ready = 1;
    step();
    chk("restart_pc0", bus.out_pc, 0);
    for (int n = 0; n < 500; n++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.redirect_valid = $urandom_range(0, 19) == 0;
      bus.redirect_pc = $urandom_range(0, 70);
      step();
    end
    bus.redirect_valid = 0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
